// File: rtl/bcd_bin_pkg.sv
// Shared widths, step count and FSM state type for the BCD-to-binary converter.
package bcd_bin_pkg;
   localparam int BIN_W  = 8;
   localparam int BCD_W  = 10;
   localparam int NDIG   = 3;
   localparam int STEPS  = BIN_W;
   localparam int WORK_W = 4 * NDIG + BIN_W;
   localparam int CNT_W  = $clog2(STEPS);

   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;
endpackage

// File: rtl/bcd_digit_adj.sv
// Reverse double-dabble digit correction: a nibble of 8 or more after a right
// shift carried in half of ten (i.e. 8 instead of 5), so take 3 back off.
module bcd_digit_adj (
   input  logic [3:0] nib,
   output logic [3:0] adj
);
   always_comb begin
      adj = nib[3] ? (nib - 4'd3) : nib;
   end
endmodule

// File: rtl/bcd_bin.sv
// Sequential 3-digit BCD to 8-bit binary converter (reverse double-dabble).
// Optional input/overflow checking is built when BCD_BIN_CHK_EN is defined.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for din_vld; loads the work register on accept
//   SHIFT | one shift + digit correction per cycle, 8 steps, then result
module bcd_bin
   import bcd_bin_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [BCD_W-1:0] bcd_in,
   input  logic             din_vld,
   output logic [BIN_W-1:0] bin_out,
   output logic             dout_vld,
   output logic             busy,
   output logic             err
);

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  step_cnt, step_nxt;
   logic [WORK_W-1:0] work, work_nxt, shifted, corrected;
   logic [BIN_W-1:0]  bin_nxt, result_bin;
   logic              busy_nxt, dout_vld_nxt;
   logic              last_step, accept;

   assign shifted   = work >> 1;
   assign last_step = (step_cnt == LAST_STEP);
   assign accept    = (state == IDLE) && din_vld;

   assign corrected[BIN_W-1:0] = shifted[BIN_W-1:0];
   for (genvar i = 0; i < NDIG; i++) begin : g_adj
      bcd_digit_adj u_adj (
         .nib (shifted[BIN_W + 4*i +: 4]),
         .adj (corrected[BIN_W + 4*i +: 4])
      );
   end

`ifdef BCD_BIN_CHK_EN
   logic                  digit_bad, digit_bad_in, chk_fail;
   logic [4*NDIG-1:0]     residual;

   assign digit_bad_in = (bcd_in[3:0] > 4'd9) || (bcd_in[7:4] > 4'd9) || (bcd_in[9:8] == 2'd3);
   // Anything left in the BCD field after the last shift is a value above 255.
   assign residual     = shifted[WORK_W-1:BIN_W];
   assign chk_fail     = digit_bad || (|residual);
   assign result_bin   = chk_fail ? '0 : shifted[BIN_W-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         digit_bad <= 1'b0;
         err       <= 1'b0;
      end else begin
         if (accept) digit_bad <= digit_bad_in;
         if ((state == SHIFT) && last_step) err <= chk_fail;
      end
   end
`else
   assign result_bin = shifted[BIN_W-1:0];
   assign err        = 1'b0;
`endif

   always_comb begin
      state_nxt    = state;
      step_nxt     = step_cnt;
      work_nxt     = work;
      busy_nxt     = busy;
      dout_vld_nxt = 1'b0;
      bin_nxt      = bin_out;
      case (state)
         IDLE: begin
            if (din_vld) begin
               state_nxt = SHIFT;
               step_nxt  = '0;
               work_nxt  = {2'b00, bcd_in, {BIN_W{1'b0}}};
               busy_nxt  = 1'b1;
            end
         end
         SHIFT: begin
            step_nxt = step_cnt + 1'b1;
            if (last_step) begin
               // Final shift is taken uncorrected; accumulator is complete.
               work_nxt     = shifted;
               state_nxt    = IDLE;
               busy_nxt     = 1'b0;
               dout_vld_nxt = 1'b1;
               bin_nxt      = result_bin;
            end else begin
               work_nxt = corrected;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         step_cnt <= '0;
         work     <= '0;
         busy     <= 1'b0;
         dout_vld <= 1'b0;
         bin_out  <= '0;
      end else begin
         state    <= state_nxt;
         step_cnt <= step_nxt;
         work     <= work_nxt;
         busy     <= busy_nxt;
         dout_vld <= dout_vld_nxt;
         bin_out  <= bin_nxt;
      end
   end

endmodule

// File: tb/tb_bcd_bin.sv
// Directed bench for bcd_bin: expected results are queued at strobe time and
// compared by a monitor whenever dout_vld is seen.
module tb_bcd_bin;

   logic       clk;
   logic       rst;
   logic [9:0] bcd_in;
   logic       din_vld;
   logic [7:0] bin_out;
   logic       dout_vld;
   logic       busy;
   logic       err;

   typedef struct {
      logic [7:0] bin;
      logic       err;
      logic [9:0] src;
   } exp_t;

   exp_t exp_q[$];
   int   tests  = 0;
   int   failed = 0;
   int   n_dout = 0;

   bcd_bin dut (
      .clk      (clk),
      .rst      (rst),
      .bcd_in   (bcd_in),
      .din_vld  (din_vld),
      .bin_out  (bin_out),
      .dout_vld (dout_vld),
      .busy     (busy),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic exp_t model(input logic [9:0] b);
      exp_t r;
      int h, t, o, v;
      h = int'(b[9:8]);
      t = int'(b[7:4]);
      o = int'(b[3:0]);
      v = h * 100 + t * 10 + o;
      r.src = b;
`ifdef BCD_BIN_CHK_EN
      r.err = (o > 9) || (t > 9) || (h == 3) || (v > 255);
      r.bin = r.err ? 8'h00 : 8'(v);
`else
      r.err = 1'b0;
      r.bin = 8'(v % 256);
`endif
      return r;
   endfunction

   // Scoreboard side: every dout_vld must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!rst && dout_vld) begin
         exp_t e;
         n_dout++;
         check("dout_without_busy", {31'd0, busy}, 32'd0);
         check("result_pending", {31'd0, (exp_q.size() != 0)}, 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check($sformatf("bin_out[%03h]", e.src), {24'd0, bin_out}, {24'd0, e.bin});
            check($sformatf("err[%03h]", e.src), {31'd0, err}, {31'd0, e.err});
         end
      end
   end

   // Called at a negedge; returns at the negedge after the sampling edge.
   task automatic strobe(input logic [9:0] v, input bit accepted);
      bcd_in  = v;
      din_vld = 1'b1;
      if (accepted) exp_q.push_back(model(v));
      @(negedge clk);
      din_vld = 1'b0;
      bcd_in  = 10'($urandom());
   endtask

   task automatic wait_result(output int lat, output int bcnt);
      lat  = 0;
      bcnt = 0;
      while (!dout_vld && lat < 30) begin
         if (busy) bcnt++;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic convert(input logic [9:0] v);
      int lat, bcnt;
      strobe(v, 1'b1);
      wait_result(lat, bcnt);
      check($sformatf("latency[%03h]", v), 32'(lat), 32'd8);
      check($sformatf("busy_cycles[%03h]", v), 32'(bcnt), 32'd8);
      @(negedge clk);
      check($sformatf("dout_one_cycle[%03h]", v), {31'd0, dout_vld}, 32'd0);
   endtask

   initial begin
      int lat, bcnt, d0;
      rst     = 1'b1;
      din_vld = 1'b0;
      bcd_in  = 10'h000;
      repeat (3) @(negedge clk);
      check("rst_bin_out", {24'd0, bin_out}, 32'd0);
      check("rst_dout_vld", {31'd0, dout_vld}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      convert(10'h231);
      convert(10'h000);
      convert(10'h255);
      convert(10'h099);
      convert(10'h100);
`ifdef BCD_BIN_CHK_EN
      convert(10'h256);
      convert(10'h0A5);
      convert(10'h300);
`else
      convert(10'h256);
`endif

      // Strobe while busy is dropped.
      d0 = n_dout;
      strobe(10'h123, 1'b1);
      repeat (2) @(negedge clk);
      check("busy_at_second_strobe", {31'd0, busy}, 32'd1);
      strobe(10'h045, 1'b0);
      repeat (20) @(negedge clk);
      check("dropped_strobe_outputs", 32'(n_dout - d0), 32'd1);

      // Back-to-back: new strobe in the dout_vld cycle.
      strobe(10'h150, 1'b1);
      wait_result(lat, bcnt);
      check("b2b_first_latency", 32'(lat), 32'd8);
      strobe(10'h077, 1'b1);
      check("b2b_accept_busy", {31'd0, busy}, 32'd1);
      wait_result(lat, bcnt);
      check("b2b_result_gap", 32'(lat + 1), 32'd9);
      @(negedge clk);

      // Reset mid-conversion aborts without a result.
      d0 = n_dout;
      strobe(10'h199, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_bin_out", {24'd0, bin_out}, 32'd0);
      check("abort_dout_vld", {31'd0, dout_vld}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_err", {31'd0, err}, 32'd0);
      repeat (15) @(negedge clk);
      check("abort_no_output", 32'(n_dout - d0), 32'd0);
      convert(10'h042);

      repeat (3) @(negedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/bcd_bin.md
# bcd_bin

Sequential BCD-to-binary converter: the inverse of the `bin_bcd` converter in the same datapath. It accepts a 3-digit packed BCD value (0–299 representable) and produces the 8-bit binary equivalent using iterative reverse double-dabble: one shift-right plus digit correction per clock. It sits on the display/keypad side of the data clock path, where digit-entered values are turned back into binary for counters and comparators.

## Interface
- Parameters: none overridable. Widths are fixed constants in the package: BIN_W = 8 and BCD_W = 10.
- `clk`  in  1  single system clock; all logic is on posedge.
- `rst`  in  1  reset, synchronous and active-high.
- `bcd_in`  in  10  packed BCD: [9:8] hundreds (0–2 legal), [7:4] tens, [3:0] ones.
- `din_vld`  in  1  one-cycle strobe. `bcd_in` is sampled on the same edge.
- `bin_out`  out  8  conversion result. Held until the next result.
- `dout_vld`  out  1  one-cycle pulse; `bin_out` and `err` are valid in that cycle.
- `busy`  out  1  conversion in progress. `din_vld` is ignored while high.
- `err`  out  1  result invalid. Meaningful only with `dout_vld`.

## Operation
- Work register: 20 bits, laid out as {hundreds padded to 4 bits, tens, ones, 8-bit binary accumulator}.
- Load: {2'b00, `bcd_in`, 8'h00}.
- FSM states:
  - IDLE. If `din_vld` is high, load the work register, clear the step counter and go to SHIFT. Otherwise stay.
  - SHIFT. Perform one step per cycle:
    - shift the whole register right by 1;
    - then, for each of the 3 BCD nibbles, if nibble >= 8, subtract 3.
  - After step 8, return to IDLE.
- No correction is applied after the 8th shift. The final binary is the accumulator after shift 8.
- Overflow: after 8 steps, a nonzero residual BCD field means the value was > 255.
- Result on step 8:
  - `bin_out` <= accumulator, or 8'h00 when `err` is set.
  - `err` <= check result (see Configuration).
  - `dout_vld` <= 1.
- `din_vld` while `busy` is high is dropped, with no queue and no side effect.
- `bcd_in` is captured only at accept. Later changes to it have no effect.

## Timing
- Reset values: `bin_out` = 8'h00, `dout_vld` = 0, `busy` = 0, `err` = 0, state = IDLE, step counter = 0.
- Accept at edge N: `busy` = 1 from N. Steps run on edges N+1 through N+8.
- At edge N+8, `bin_out`, `err` and `dout_vld` = 1 are registered and `busy` falls.
- Latency is 8 cycles from the accept edge to the `dout_vld` cycle.
- `dout_vld` is high for exactly one cycle and never coincides with `busy`.
- A new `din_vld` is accepted at the earliest on edge N+8's following edge (N+9, the `dout_vld` cycle). Maximum throughput is one conversion per 9 cycles.
- `rst` asserted mid-conversion: the next edge returns every register to its reset value. No `dout_vld` is issued for the aborted input.
- `rst` and `din_vld` high on the same edge: `rst` wins and the input is dropped.

## Configuration
- Macro: `BCD_BIN_CHK_EN`.
- Defined:
  - `err` = 1 if any of: ones > 9, tens > 9, hundreds == 3 (all checked at accept), or residual BCD field nonzero after step 8.
  - `bin_out` is forced to 0 on error.
- Undefined:
  - `err` is tied to 0 and no check logic is built.
  - `bin_out` is the raw accumulator: value mod 256 for legal digits, and deterministic but unspecified for illegal digits.

## Structure
- Package `bcd_bin_pkg` holds:
  - BIN_W, BCD_W, NDIG = 3;
  - the step count (= BIN_W);
  - the FSM state enum {IDLE, SHIFT}.
- One sub-module, `bcd_digit_adj`: 4-bit combinational "nibble >= 8 ? nibble - 3 : nibble". It is instantiated NDIG times.
- The top holds the FSM, step counter, work register and output registers.

## Test plan
- Reset for 3 cycles, then `bcd_in` = 10'h231 and `din_vld` for 1 cycle -> after 8 cycles, `dout_vld` pulses with `bin_out` = 8'd231 (8'hE7) and `err` = 0. During the conversion, `busy` is high for 8 cycles.
- Corner values:
  - 10'h000 -> 8'd0;
  - 10'h255 -> 8'd255;
  - 10'h099 -> 8'd99;
  - 10'h100 -> 8'd100;
  - all with `err` = 0.
- With `BCD_BIN_CHK_EN`:
  - 10'h256 -> `err` = 1, `bin_out` = 0;
  - 10'h0A5 -> `err` = 1;
  - 10'h300 -> `err` = 1.
- Without the macro, 10'h256 -> `err` = 0, `bin_out` = 8'd0 (256 mod 256).
- `din_vld` with 10'h123 at accept, then a second `din_vld` with 10'h045 three cycles later -> only 8'd123 is output, with exactly one `dout_vld`.
- Back-to-back: a second strobe in the `dout_vld` cycle -> it is accepted, and its result follows 9 cycles after the first result.
- `rst` pulsed 4 cycles after accepting 10'h199 -> no `dout_vld`, all outputs 0. The next conversion of 10'h042 gives 8'd42.
